// File: rtl/goto_repeat_pkg.sv
// Shared types for the goto-repetition monitor: FSM states, verdict codes
// and the counter-width helper.
package goto_repeat_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      EXPECT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      FC_NONE         = 2'd0,
      FC_TIMEOUT      = 2'd1,
      FC_DONE_MISSING = 2'd2
   } fail_code_e;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/goto_repeat_monitor.sv
// Hardware form of "start ##1 hit[->N_HITS] ##1 done" with a TIMEOUT-cycle
// counting window; emits one-cycle pass/fail pulses with a fail reason.
module goto_repeat_monitor
   import goto_repeat_pkg::*;
#(
   parameter int N_HITS  = 3,
   parameter int TIMEOUT = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      hit,
   input  logic                      done,
   output logic                      busy,
   output logic [cnt_w(N_HITS)-1:0]  hit_count,
   output logic                      pass,
   output logic                      fail,
   output logic [1:0]                fail_code
);

   localparam int HW = cnt_w(N_HITS);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [HW-1:0] LAST_HIT  = HW'(N_HITS - 1);
   localparam logic [HW-1:0] HIT_MAX   = HW'(N_HITS);
   localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

   if (N_HITS < 1) begin : g_bad_nhits
      $error("goto_repeat_monitor: N_HITS must be >= 1");
   end
   if (TIMEOUT < N_HITS) begin : g_bad_timeout
      $error("goto_repeat_monitor: TIMEOUT must be >= N_HITS");
   end

   state_e          state_q, state_d;
   logic [HW-1:0]   hit_cnt_q, hit_cnt_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            pass_q, pass_d;
   logic            fail_q, fail_d;
   fail_code_e      fcode_q, fcode_d;

   logic            nth_hit;
   assign nth_hit = hit && (hit_cnt_q == LAST_HIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         hit_cnt_q <= '0;
         timer_q   <= '0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         fcode_q   <= FC_NONE;
      end else begin
         state_q   <= state_d;
         hit_cnt_q <= hit_cnt_d;
         timer_q   <= timer_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         fcode_q   <= fcode_d;
      end
   end

   // The Nth hit takes priority over window expiry in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = COUNT;
         COUNT: begin
            if (nth_hit)                     state_d = EXPECT;
            else if (timer_q == LAST_TICK)   state_d = IDLE;
         end
         EXPECT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hit_cnt_d = hit_cnt_q;
      timer_d   = timer_q;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      fcode_d   = FC_NONE;
      case (state_q)
         IDLE: begin
            if (start) begin
               hit_cnt_d = '0;
               timer_d   = '0;
            end
         end
         COUNT: begin
            if (hit && (hit_cnt_q != HIT_MAX)) hit_cnt_d = hit_cnt_q + HW'(1);
            // Timer parks at zero on exit so it can never wrap.
            if (state_d == COUNT) timer_d = timer_q + TW'(1);
            else                  timer_d = '0;
            if (state_d == IDLE) begin
               fail_d  = 1'b1;
               fcode_d = FC_TIMEOUT;
            end
         end
         EXPECT: begin
            if (done) begin
               pass_d = 1'b1;
            end else begin
               fail_d  = 1'b1;
               fcode_d = FC_DONE_MISSING;
            end
         end
         default: begin
            hit_cnt_d = '0;
            timer_d   = '0;
         end
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign hit_count = hit_cnt_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign fail_code = fcode_q;

   a_verdict_excl: assert property (@(posedge clk) disable iff (rst) !(pass && fail));
   c_pass:         cover property (@(posedge clk) disable iff (rst) pass);
   c_timeout:      cover property (@(posedge clk) disable iff (rst)
                                   fail && (fail_code == FC_TIMEOUT));

endmodule

// File: tb/tb_goto_repeat_monitor.sv
// Bench for goto_repeat_monitor: directed vector tables for the multi-cycle
// scenarios, then random traffic against a window-arithmetic reference model.
module tb_goto_repeat_monitor;

   localparam int N = 3;
   localparam int T = 8;

   logic       clk = 1'b0;
   logic       rst, start, hit, done;
   logic       busy, pass, fail;
   logic [1:0] hit_count;
   logic [1:0] fail_code;

   goto_repeat_monitor #(.N_HITS(N), .TIMEOUT(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .hit       (hit),
      .done      (done),
      .busy      (busy),
      .hit_count (hit_count),
      .pass      (pass),
      .fail      (fail),
      .fail_code (fail_code)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       r;
      logic       s;
      logic       h;
      logic       d;
      logic       busy;
      logic [1:0] hc;
      logic       pass;
      logic       fail;
      logic [1:0] code;
   } vec_t;

   vec_t tbl[$];
   int   nvec = 0;
   int   nerr = 0;

   task automatic v(input logic r, input logic s, input logic h, input logic d,
                    input logic b, input int hc, input logic p, input logic f,
                    input int code);
      vec_t e;
      e.r = r; e.s = s; e.h = h; e.d = d;
      e.busy = b; e.hc = 2'(hc); e.pass = p; e.fail = f; e.code = 2'(code);
      tbl.push_back(e);
   endtask

   // Drives one cycle of inputs and checks the registered outputs after the edge.
   task automatic apply(input logic r, input logic s, input logic h, input logic d,
                        input logic [6:0] exp, input string name, input int idx);
      logic [6:0] act;
      rst = r; start = s; hit = h; done = d;
      @(posedge clk);
      #1;
      act = {busy, hit_count, pass, fail, fail_code};
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s[%0d]: got busy/hc/pass/fail/code=%b/%0d/%b/%b/%0d, want %b/%0d/%b/%b/%0d",
                  name, idx, act[6], act[5:4], act[3], act[2], act[1:0],
                  exp[6], exp[5:4], exp[3], exp[2], exp[1:0]);
      end
   endtask

   // Reference model: tracks an attempt by its start cycle and the window
   // offset of each cycle, rather than by a timer.
   bit  m_armed = 0;
   int  m_start = 0;
   int  m_hc    = 0;
   bit  m_expect = 0;
   int  cyc     = 0;

   task automatic model_step(input logic r, input logic s, input logic h, input logic d,
                             output logic [6:0] exp);
      logic p, f;
      int   code;
      int   w;
      p = 0; f = 0; code = 0;
      if (r) begin
         m_armed = 0; m_hc = 0; m_expect = 0;
      end else if (!m_armed) begin
         if (s) begin
            m_armed = 1; m_start = cyc; m_hc = 0; m_expect = 0;
         end
      end else if (m_expect) begin
         if (d) p = 1;
         else begin f = 1; code = 2; end
         m_armed = 0; m_expect = 0;
      end else begin
         w = cyc - m_start;
         if (h) m_hc++;
         if (h && m_hc == N) m_expect = 1;
         else if (w == T) begin
            f = 1; code = 1; m_armed = 0;
         end
      end
      cyc++;
      exp = {m_armed, 2'(m_hc), p, f, 2'(code)};
   endtask

   initial begin
      logic [6:0] exp;
      logic r, s, h, d;
      rst = 1; start = 0; hit = 0; done = 0;
      @(posedge clk);
      #1;

      // reset state
      v(1,0,0,0, 0,0,0,0,0);
      // hits at 2,4,5; done at 6 -> pass at 7; start re-asserted at 3 ignored;
      // start during the pass cycle accepted; then reset abandons it
      v(0,1,0,0, 1,0,0,0,0);
      v(0,0,0,0, 1,0,0,0,0);
      v(0,0,1,0, 1,1,0,0,0);
      v(0,1,0,0, 1,1,0,0,0);
      v(0,0,1,0, 1,2,0,0,0);
      v(0,0,1,0, 1,3,0,0,0);
      v(0,0,0,1, 0,3,1,0,0);
      v(0,1,0,0, 1,0,0,0,0);
      v(1,0,0,0, 0,0,0,0,0);
      // hits at 1,2,3; done missing at 4 -> fail DONE_MISSING at 5
      v(0,1,0,0, 1,0,0,0,0);
      v(0,0,1,0, 1,1,0,0,0);
      v(0,0,1,0, 1,2,0,0,0);
      v(0,0,1,0, 1,3,0,0,0);
      v(0,0,1,0, 0,3,0,1,2);
      v(0,0,0,0, 0,3,0,0,0);
      // hits at 2,5 only -> fail TIMEOUT at 9, hit_count holds 2
      v(0,1,0,0, 1,0,0,0,0);
      v(0,0,0,0, 1,0,0,0,0);
      v(0,0,1,0, 1,1,0,0,0);
      v(0,0,0,0, 1,1,0,0,0);
      v(0,0,0,0, 1,1,0,0,0);
      v(0,0,1,0, 1,2,0,0,0);
      v(0,0,0,0, 1,2,0,0,0);
      v(0,0,0,0, 1,2,0,0,0);
      v(0,0,0,0, 0,2,0,1,1);
      v(0,0,0,0, 0,2,0,0,0);
      // hit at 0 ignored; hits 3,6,8 (last window cycle); done at 9 -> pass at 10
      v(0,1,1,0, 1,0,0,0,0);
      v(0,0,0,0, 1,0,0,0,0);
      v(0,0,0,0, 1,0,0,0,0);
      v(0,0,1,0, 1,1,0,0,0);
      v(0,0,0,0, 1,1,0,0,0);
      v(0,0,0,0, 1,1,0,0,0);
      v(0,0,1,0, 1,2,0,0,0);
      v(0,0,0,0, 1,2,0,0,0);
      v(0,0,1,0, 1,3,0,0,0);
      v(0,0,0,1, 0,3,1,0,0);
      v(0,0,0,0, 0,3,0,0,0);
      // reset at 3 after a hit at 2; restart at 5, hits 6,7,8, done 9 -> pass at 10
      v(0,1,0,0, 1,0,0,0,0);
      v(0,0,0,0, 1,0,0,0,0);
      v(0,0,1,0, 1,1,0,0,0);
      v(1,1,1,1, 0,0,0,0,0);
      v(0,0,0,0, 0,0,0,0,0);
      v(0,1,0,0, 1,0,0,0,0);
      v(0,0,1,0, 1,1,0,0,0);
      v(0,0,1,0, 1,2,0,0,0);
      v(0,0,1,0, 1,3,0,0,0);
      v(0,0,0,1, 0,3,1,0,0);
      v(0,0,0,0, 0,3,0,0,0);
      // hit during EXPECT is ignored and hit_count holds at N
      v(0,1,0,0, 1,0,0,0,0);
      v(0,0,1,0, 1,1,0,0,0);
      v(0,0,1,0, 1,2,0,0,0);
      v(0,0,1,0, 1,3,0,0,0);
      v(0,0,1,1, 0,3,1,0,0);

      foreach (tbl[i])
         apply(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].d,
               {tbl[i].busy, tbl[i].hc, tbl[i].pass, tbl[i].fail, tbl[i].code},
               "tbl", i);

      for (int i = 0; i < 4000; i++) begin
         r = (i == 0) || ($urandom_range(0, 99) == 0);
         s = ($urandom_range(0, 3) == 0);
         h = ($urandom_range(0, 2) == 0);
         d = ($urandom_range(0, 1) == 0);
         model_step(r, s, h, d, exp);
         apply(r, s, h, d, exp, "rnd", i);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
